// File: rtl/multicycle_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_data_memory_responder
// Description : Word-organised data memory that serves one byte/half/word load
//               or store at a time after a fixed number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_data_memory_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [2:0]  data_format,
    output logic        ready,
    output logic [31:0] read_data,
    output logic        error
);

    localparam int         c_IDX_W   = $clog2(WORDS);
    localparam logic [3:0] c_LAT     = 4'(LATENCY);
    localparam logic [2:0] c_FMT_B   = 3'b000;
    localparam logic [2:0] c_FMT_H   = 3'b001;
    localparam logic [2:0] c_FMT_W   = 3'b010;
    localparam logic [2:0] c_FMT_BU  = 3'b100;
    localparam logic [2:0] c_FMT_HU  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_count;
    logic [3:0]           w_next_count;
    logic                 w_capture;

    logic [c_IDX_W+1:0]   r_addr;
    logic [31:0]          r_wdata;
    logic [2:0]           r_fmt;
    logic                 r_is_read;
    logic                 r_is_write;

    logic [31:0]          r_mem [WORDS];

    logic [c_IDX_W-1:0]   w_index;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;
    logic [3:0]           w_be;
    logic [31:0]          w_store_lanes;
    logic [31:0]          w_merged;
    logic                 w_conflict;
    logic                 w_reserved;
    logic                 w_misaligned;
    logic                 w_bad;
    logic                 w_commit;

    // Address bits above the word index alias onto the same storage.
    logic                 w_unused_addr;
    assign w_unused_addr = &{1'b0, address[31:c_IDX_W+2]};

    // ------------------------------------------------------------------
    // Request capture and FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_fmt      <= 3'd0;
            r_is_read  <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_capture) begin
                r_addr     <= address[c_IDX_W+1:0];
                r_wdata    <= write_data;
                r_fmt      <= data_format;
                r_is_read  <= read_enable;
                r_is_write <= write_enable;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (read_enable | write_enable) begin
                    w_capture = 1'b1;
                    if (c_LAT == 4'd0) begin
                        w_next_state = ST_RESPOND;
                        w_next_count = 4'd0;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_count = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_count == c_LAT) begin
                    w_next_state = ST_RESPOND;
                    w_next_count = 4'd0;
                end else begin
                    w_next_count = r_count + 4'd1;
                end
            end
            ST_RESPOND: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request legality
    // ------------------------------------------------------------------
    always_comb begin
        w_conflict = r_is_read & r_is_write;
        case (r_fmt)
            c_FMT_B, c_FMT_H, c_FMT_W: w_reserved = 1'b0;
            c_FMT_BU, c_FMT_HU:        w_reserved = r_is_write;
            default:                   w_reserved = 1'b1;
        endcase
        case (r_fmt[1:0])
            2'b01:   w_misaligned = r_addr[0];
            2'b10:   w_misaligned = |r_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
        w_bad = w_conflict | w_reserved | w_misaligned;
    end

    // ------------------------------------------------------------------
    // Storage access: load extraction and store byte-lane merge
    // ------------------------------------------------------------------
    assign w_index = r_addr[c_IDX_W+1:2];
    assign w_word  = r_mem[w_index];
    assign w_byte  = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_word[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_fmt[1:0])
            2'b00:   w_load = {{24{~r_fmt[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_fmt[2] & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated into every lane; the byte enables pick the live ones.
    always_comb begin
        case (r_fmt[1:0])
            2'b00: begin
                w_be          = 4'b0001 << r_addr[1:0];
                w_store_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be          = r_addr[1] ? 4'b1100 : 4'b0011;
                w_store_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be          = 4'b1111;
                w_store_lanes = r_wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = w_be[gi] ? w_store_lanes[8*gi +: 8]
                                                  : w_word[8*gi +: 8];
        end
    endgenerate

    assign w_commit = (r_state == ST_RESPOND) & r_is_write & ~w_bad;

    // Storage survives reset by design, so this array carries no reset.
    always_ff @(posedge clock) begin
        if (w_commit) begin
            r_mem[w_index] <= w_merged;
        end
    end

    // ------------------------------------------------------------------
    // Response outputs, qualified by the single RESPOND cycle
    // ------------------------------------------------------------------
    always_comb begin
        ready     = (r_state == ST_RESPOND);
        error     = ready & w_bad;
        read_data = (ready & r_is_read & ~w_bad) ? w_load : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_data_memory_responder
// Description : Bench for the data memory responder at latencies 2, 0 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_data_memory_responder;

    localparam logic [2:0] c_B  = 3'b000;
    localparam logic [2:0] c_H  = 3'b001;
    localparam logic [2:0] c_W  = 3'b010;
    localparam logic [2:0] c_BU = 3'b100;
    localparam logic [2:0] c_HU = 3'b101;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       re;
    logic [2:0]       we;
    logic [2:0]       rdy;
    logic [2:0]       err;
    logic [2:0][31:0] addr;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;
    logic [2:0][2:0]  fmt;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t vt[$];

    always #5 clock = ~clock;

    multicycle_data_memory_responder #(.WORDS(1024), .LATENCY(2)) dut_l2 (
        .clock(clock), .reset(reset), .address(addr[0]), .write_data(wdata[0]),
        .read_enable(re[0]), .write_enable(we[0]), .data_format(fmt[0]),
        .ready(rdy[0]), .read_data(rdata[0]), .error(err[0]));

    multicycle_data_memory_responder #(.WORDS(1024), .LATENCY(0)) dut_l0 (
        .clock(clock), .reset(reset), .address(addr[1]), .write_data(wdata[1]),
        .read_enable(re[1]), .write_enable(we[1]), .data_format(fmt[1]),
        .ready(rdy[1]), .read_data(rdata[1]), .error(err[1]));

    multicycle_data_memory_responder #(.WORDS(1024), .LATENCY(3)) dut_l3 (
        .clock(clock), .reset(reset), .address(addr[2]), .write_data(wdata[2]),
        .read_enable(re[2]), .write_enable(we[2]), .data_format(fmt[2]),
        .ready(rdy[2]), .read_data(rdata[2]), .error(err[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic void push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Response monitor: pops the scoreboard on every ready pulse.
    logic [2:0] prev_rdy = 3'b000;
    exp_t       m_e;
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (rdy[d] === 1'b1) begin
                n_cmp++;
                if (prev_rdy[d]) begin
                    n_fail++;
                    $display("FAIL pulse_width dut%0d: ready high 2 cycles in a row, required 1", d);
                end
                n_cmp++;
                if (qsize(d) == 0) begin
                    n_fail++;
                    $display("FAIL spurious_ready dut%0d: ready=1 with no request outstanding", d);
                end else begin
                    m_e = pop_exp(d);
                    if (rdata[d] !== m_e.data || err[d] !== m_e.err) begin
                        n_fail++;
                        $display("FAIL response dut%0d: got data=%h err=%b, required data=%h err=%b",
                                 d, rdata[d], err[d], m_e.data, m_e.err);
                    end
                end
            end else begin
                n_cmp++;
                if (rdy[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_outputs dut%0d: got ready=%b data=%h, required ready=0 data=0",
                             d, rdy[d], rdata[d]);
                end
            end
            prev_rdy[d] = rdy[d];
        end
    end

    // Issue one request and hold it until ready; the monitor checks the payload.
    task automatic req(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f,
                       input logic [31:0] ed, input bit ee);
        int k;
        bit seen;
        exp_t e;
        re[d]    = rd;
        we[d]    = wr;
        addr[d]  = a;
        wdata[d] = wd;
        fmt[d]   = f;
        e.data   = ed;
        e.err    = ee;
        push_exp(d, e);
        k    = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clock);
            if (rdy[d] === 1'b1) seen = 1;
            else k++;
        end
        n_cmp++;
        if (!seen || k != lat_of(d) + 1) begin
            n_fail++;
            $display("FAIL latency dut%0d addr=%h: got %0d cycles (seen=%0b), required %0d",
                     d, a, k, seen, lat_of(d) + 1);
            if (!seen && qsize(d) > 0) e = pop_exp(d);
        end
        @(posedge clock);
        #1;
        re[d] = 1'b0;
        we[d] = 1'b0;
    endtask

    task automatic add_vec(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f,
                           input logic [31:0] ed, input bit ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.f = f; v.ed = ed; v.ee = ee;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        bit   seen;
        time  t0;

        re = '0; we = '0; addr = '0; wdata = '0; fmt = '0;

        //      rd wr addr           wdata          fmt     expected data  err
        add_vec(0, 1, 32'h0000_0100, 32'hDEADBEEF, c_W,    32'h0,         0);
        add_vec(1, 0, 32'h0000_0100, 32'h0,        c_W,    32'hDEADBEEF,  0);
        add_vec(0, 1, 32'h0000_0200, 32'h11223344, c_W,    32'h0,         0);
        add_vec(0, 1, 32'h0000_0201, 32'hFFFFFFAA, c_B,    32'h0,         0);
        add_vec(1, 0, 32'h0000_0200, 32'h0,        c_W,    32'h1122AA44,  0);
        add_vec(1, 0, 32'h0000_0201, 32'h0,        c_BU,   32'h000000AA,  0);
        add_vec(1, 0, 32'h0000_0201, 32'h0,        c_B,    32'hFFFFFFAA,  0);
        add_vec(0, 1, 32'h0000_0040, 32'h80007FFF, c_W,    32'h0,         0);
        add_vec(1, 0, 32'h0000_0042, 32'h0,        c_H,    32'hFFFF8000,  0);
        add_vec(1, 0, 32'h0000_0042, 32'h0,        c_HU,   32'h00008000,  0);
        add_vec(1, 0, 32'h0000_0040, 32'h0,        c_H,    32'h00007FFF,  0);
        add_vec(0, 1, 32'h0000_0102, 32'h12345678, c_W,    32'h0,         1);
        add_vec(1, 0, 32'h0000_0100, 32'h0,        c_W,    32'hDEADBEEF,  0);
        add_vec(1, 0, 32'h0000_0100, 32'h0,        3'b011, 32'h0,         1);
        add_vec(1, 1, 32'h0000_0100, 32'h0,        c_W,    32'h0,         1);
        add_vec(1, 0, 32'h0000_0100, 32'h0,        c_W,    32'hDEADBEEF,  0);
        add_vec(0, 1, 32'h0000_0202, 32'h0000BEEF, c_H,    32'h0,         0);
        add_vec(1, 0, 32'h0000_0200, 32'h0,        c_W,    32'hBEEFAA44,  0);
        add_vec(1, 0, 32'h0000_0201, 32'h0,        c_H,    32'h0,         1);
        add_vec(0, 1, 32'h0000_0200, 32'h000000FF, c_BU,   32'h0,         1);
        add_vec(0, 1, 32'h0000_0203, 32'h000000FF, 3'b110, 32'h0,         1);
        add_vec(1, 0, 32'h0000_0200, 32'h0,        c_W,    32'hBEEFAA44,  0);
        add_vec(1, 0, 32'h0000_1100, 32'h0,        c_W,    32'hDEADBEEF,  0);
        add_vec(1, 0, 32'hFFFF_F100, 32'h0,        c_W,    32'hDEADBEEF,  0);
        add_vec(1, 0, 32'h0000_0203, 32'h0,        c_B,    32'hFFFFFFBE,  0);
        add_vec(1, 0, 32'h0000_0200, 32'h0,        c_BU,   32'h00000044,  0);
        add_vec(1, 0, 32'h0000_0202, 32'h0,        c_HU,   32'h0000BEEF,  0);
        add_vec(1, 0, 32'h0000_0202, 32'h0,        c_H,    32'hFFFFBEEF,  0);
        add_vec(1, 0, 32'h0000_0103, 32'h0,        c_W,    32'h0,         1);
        add_vec(1, 0, 32'h0000_0100, 32'h0,        3'b111, 32'h0,         1);
        add_vec(0, 1, 32'h0000_1203, 32'h00000011, c_B,    32'h0,         0);
        add_vec(1, 0, 32'h0000_0200, 32'h0,        c_W,    32'h11EFAA44,  0);

        // Reset state
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (rdy[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got ready=%b data=%h err=%b, required 0/0/0",
                         d, rdy[d], rdata[d], err[d]);
            end
        end
        @(posedge clock);
        #1 reset = 1'b1;

        // Reset in the middle of a store's wait states discards the store
        req(0, 0, 1, 32'h10, 32'hA5A5A5A5, c_W, 32'h0, 0);
        we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h5A5A5A5A; fmt[0] = c_W;
        @(posedge clock);
        #1;
        we[0] = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got ready=%b data=%h, required 0/0", rdy[0], rdata[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (rdy[0] !== 1'b0 || rdata[0] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got ready=%b data=%h, required 0/0", rdy[0], rdata[0]);
            end
        end
        @(posedge clock);
        #1 reset = 1'b1;
        req(0, 1, 0, 32'h10, 32'h0, c_W, 32'hA5A5A5A5, 0);

        // Table-driven vectors on the LATENCY=2 instance
        foreach (vt[i]) begin
            req(0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, vt[i].f, vt[i].ed, vt[i].ee);
        end

        // LATENCY=0: back-to-back requests each take two cycles
        req(1, 0, 1, 32'h8, 32'h01020304, c_W, 32'h0, 0);
        t0 = $time;
        req(1, 1, 0, 32'h8, 32'h0, c_W, 32'h01020304, 0);
        req(1, 1, 0, 32'h9, 32'h0, c_B, 32'h00000003, 0);
        req(1, 1, 0, 32'hA, 32'h0, c_H, 32'h00000102, 0);
        n_cmp++;
        if ($time - t0 != 60) begin
            n_fail++;
            $display("FAIL back_to_back: got %0t time units for 3 reads, required 60", $time - t0);
        end

        // LATENCY=3: inputs dropped and scrambled after capture
        req(2, 0, 1, 32'h20, 32'hCAFEF00D, c_W, 32'h0, 0);
        re[2] = 1'b1; addr[2] = 32'h20; fmt[2] = c_W;
        push_exp(2, '{data: 32'hCAFEF00D, err: 1'b0});
        @(posedge clock);
        #1;
        re[2] = 1'b0; addr[2] = 32'h999; fmt[2] = 3'b111;
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clock);
            if (rdy[2] === 1'b1) seen = 1;
            else k++;
        end
        n_cmp++;
        if (!seen || k != 3) begin
            n_fail++;
            $display("FAIL drop_latency: got %0d cycles (seen=%0b), required 3", k, seen);
        end

        // Let any stray pulses surface, then confirm nothing is left outstanding
        repeat (8) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (qsize(d) != 0) begin
                n_fail++;
                $display("FAIL outstanding dut%0d: got %0d unanswered requests, required 0",
                         d, qsize(d));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
